// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared constants and helpers for the control-signal pipeline.
// Bubble counters exist only when CTRL_PIPE_PERF_EN is defined.
package ctrl_pipe_pkg;

  // Bubble counter width and saturation value
  localparam int CTRL_PIPE_CNT_W = 32;
  localparam logic [CTRL_PIPE_CNT_W-1:0] CTRL_PIPE_CNT_MAX = '1;

  // Default geometry of the MIPS control bundle: decode feeds E, M, W
  localparam int CTRL_PIPE_WIDTH  = 45;
  localparam int CTRL_PIPE_STAGES = 3;

  typedef logic [CTRL_PIPE_CNT_W-1:0] ctrlPipeCntT;

  // Increment that sticks at the maximum instead of wrapping
  function automatic ctrlPipeCntT ctrlPipeSatInc(input ctrlPipeCntT value);
    return (value == CTRL_PIPE_CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: groups the decode-side handshake, per-stage controls and the
// per-stage outputs of ctrl_pipe_chain. The controller drives it as master.
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH  = CTRL_PIPE_WIDTH,
  parameter int STAGES = CTRL_PIPE_STAGES
);

  logic [WIDTH-1:0]                  in_data;
  logic                              in_valid;
  logic                              in_ready;
  logic [STAGES-1:0]                 stall;
  logic [STAGES-1:0]                 flush;
  logic [STAGES*WIDTH-1:0]           out_data;
  logic [STAGES-1:0]                 out_valid;
  logic                              perf_clr;
  logic [STAGES*CTRL_PIPE_CNT_W-1:0] bubble_cnt;

  modport master (
    output in_data, in_valid, stall, flush, perf_clr,
    input  in_ready, out_data, out_valid, bubble_cnt
  );

  modport slave (
    input  in_data, in_valid, stall, flush, perf_clr,
    output in_ready, out_data, out_valid, bubble_cnt
  );

endinterface

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one control-bundle register with its valid bit.
// An invalid stage always holds an all-zero bundle so consumers need not gate
// by valid. With CTRL_PIPE_PERF_EN defined it also counts bubble cycles.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             srcValid,
  input  logic [WIDTH-1:0] srcData,
  input  logic             perfClr,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output ctrlPipeCntT      bubbleCnt
);

  logic             validReg;
  logic [WIDTH-1:0] dataReg;

  // Stage register: reset, then flush (beats hold), hold, bubble, load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      validReg <= 1'b0;
      dataReg  <= '0;
    end else if (hold) begin
      validReg <= validReg;
      dataReg  <= dataReg;
    end else if (bubble) begin
      validReg <= 1'b0;
      dataReg  <= '0;
    end else begin
      validReg <= srcValid;
      dataReg  <= srcData;
    end
  end

  assign valid = validReg;
  assign data  = dataReg;

`ifdef CTRL_PIPE_PERF_EN
  ctrlPipeCntT bubbleCntReg;

  // Bubble counter: counts cycles the registered valid is low, clear wins
  always_ff @(posedge clk) begin
    if (rst || perfClr) begin
      bubbleCntReg <= '0;
    end else if (!validReg) begin
      bubbleCntReg <= ctrlPipeSatInc(bubbleCntReg);
    end
  end

  assign bubbleCnt = bubbleCntReg;
`else
  // No counter hardware; the clear input is deliberately left without a load
  logic unusedPerfClr;
  assign unusedPerfClr = perfClr;
  assign bubbleCnt     = '0;
`endif

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: carries the decoded control bundle through STAGES stage
// registers. Stalls propagate backward; a bubble is inserted behind a stalled
// stage. Define CTRL_PIPE_PERF_EN to build the per-stage bubble counters.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH  = CTRL_PIPE_WIDTH,
  parameter int STAGES = CTRL_PIPE_STAGES
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  logic [STAGES-1:0]                   effStall;
  logic [STAGES-1:0]                   stageValid;
  logic [STAGES-1:0][WIDTH-1:0]        stageData;
  logic [STAGES-1:0][CTRL_PIPE_CNT_W-1:0] stageCnt;
  logic [WIDTH-1:0]                    headData;

  // A stalled later stage freezes every earlier one
  assign effStall[STAGES-1] = bus.stall[STAGES-1];
  for (genvar gi = 0; gi < STAGES - 1; gi++) begin : gEffStall
    assign effStall[gi] = bus.stall[gi] | effStall[gi+1];
  end

  // Decode presents zeros whenever it has no real instruction
  assign headData = bus.in_valid ? bus.in_data : '0;

  for (genvar gi = 0; gi < STAGES; gi++) begin : gStage
    logic             srcValid;
    logic [WIDTH-1:0] srcData;
    logic             bubble;

    if (gi == 0) begin : gHead
      assign srcValid = bus.in_valid;
      assign srcData  = headData;
      assign bubble   = 1'b0;
    end else begin : gBody
      assign srcValid = stageValid[gi-1];
      assign srcData  = stageData[gi-1];
      assign bubble   = effStall[gi-1];
    end

    ctrl_pipe_stage #(
      .WIDTH(WIDTH)
    ) uStage (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush[gi]),
      .hold     (effStall[gi]),
      .bubble   (bubble),
      .srcValid (srcValid),
      .srcData  (srcData),
      .perfClr  (bus.perf_clr),
      .valid    (stageValid[gi]),
      .data     (stageData[gi]),
      .bubbleCnt(stageCnt[gi])
    );
  end

  assign bus.in_ready   = ~effStall[0];
  assign bus.out_valid  = stageValid;
  assign bus.out_data   = stageData;
  assign bus.bubble_cnt = stageCnt;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the stage rules.
module tb_ctrl_pipe_chain;
  import ctrl_pipe_pkg::*;

  localparam int W = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;
  int   cmpCnt = 0;
  int   errCnt = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.WIDTH(W), .STAGES(S)) bus ();

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference model state
  bit          mV[S];
  logic [W-1:0] mD[S];
  logic [31:0] mC[S];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                       input logic [S-1:0] st, input logic [S-1:0] fl, input logic clr);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.stall    = st;
    bus.flush    = fl;
    bus.perf_clr = clr;
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic modelStep();
    bit           frozen[S];
    bit           nV[S];
    logic [W-1:0] nD[S];
    bit           acc;
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        mV[i] = 0; mD[i] = '0; mC[i] = '0;
      end
      return;
    end
`ifdef CTRL_PIPE_PERF_EN
    for (int i = 0; i < S; i++) begin
      if (bus.perf_clr) mC[i] = '0;
      else if (!mV[i] && mC[i] != 32'hFFFF_FFFF) mC[i] = mC[i] + 1;
    end
`endif
    acc = 0;
    for (int i = S - 1; i >= 0; i--) begin
      acc = acc | bus.stall[i];
      frozen[i] = acc;
    end
    for (int i = 0; i < S; i++) begin
      if (bus.flush[i]) begin
        nV[i] = 0; nD[i] = '0;
      end else if (frozen[i]) begin
        nV[i] = mV[i]; nD[i] = mD[i];
      end else if (i > 0 && frozen[i-1]) begin
        nV[i] = 0; nD[i] = '0;
      end else if (i == 0) begin
        nV[i] = bus.in_valid; nD[i] = bus.in_valid ? bus.in_data : '0;
      end else begin
        nV[i] = mV[i-1]; nD[i] = mD[i-1];
      end
    end
    for (int i = 0; i < S; i++) begin
      mV[i] = nV[i]; mD[i] = nD[i];
    end
  endtask

  task automatic checkOutputs();
    logic [S-1:0]    ev;
    logic [S*W-1:0]  ed;
    logic [S*32-1:0] ec;
    for (int i = 0; i < S; i++) begin
      ev[i]          = mV[i];
      ed[i*W +: W]   = mD[i];
      ec[i*32 +: 32] = mC[i];
    end
    check("out_valid", 128'(bus.out_valid), 128'(ev));
    check("out_data", 128'(bus.out_data), 128'(ed));
    check("bubble_cnt", 128'(bus.bubble_cnt), 128'(ec));
  endtask

  // One clock: in_ready before the edge, registered outputs just after it
  task automatic cycle();
    #1;
    check("in_ready", 128'(bus.in_ready), 128'(bus.stall == '0));
    @(posedge clk);
    modelStep();
    #1;
    checkOutputs();
  endtask

  initial begin
    for (int i = 0; i < S; i++) begin
      mV[i] = 0; mD[i] = '0; mC[i] = '0;
    end
    drive(1, 0, '0, '0, '0, 0);
    @(negedge clk);
    cycle();
    $display("reset: out_valid=%b out_data=%h", bus.out_valid, bus.out_data);
    check("reset_valid", 128'(bus.out_valid), 128'(0));

`ifdef CTRL_PIPE_PERF_EN
    // Idle after reset: stage 0 counts five bubbles
    drive(0, 0, '0, '0, '0, 0);
    repeat (5) cycle();
    check("idle5_cnt0", 128'(bus.bubble_cnt[31:0]), 128'(5));
    $display("idle: bubble_cnt0=%0d", bus.bubble_cnt[31:0]);
`endif

    // Flow: 11, 22, 33 back to back
    drive(0, 1, 8'h11, '0, '0, 0); cycle();
    drive(0, 1, 8'h22, '0, '0, 0); cycle();
    drive(0, 1, 8'h33, '0, '0, 0); cycle();
    check("flow_s2_first", 128'(bus.out_data[2*W +: W]), 128'(8'h11));
    drive(0, 0, '0, '0, '0, 0); cycle();
    check("flow_s2_second", 128'(bus.out_data[2*W +: W]), 128'(8'h22));
    $display("flow: out_data=%h out_valid=%b", bus.out_data, bus.out_valid);

    // Back-stall from the last stage while streaming
    drive(0, 1, 8'h44, '0, '0, 0); cycle();
    drive(0, 1, 8'h55, 3'b100, '0, 0); cycle();
    drive(0, 1, 8'h55, 3'b100, '0, 0); cycle();
    drive(0, 1, 8'h55, '0, '0, 0); cycle();
    drive(0, 1, 8'h66, '0, '0, 0); cycle();
    check("backstall_s1", 128'(bus.out_data[W +: W]), 128'(8'h55));
    $display("backstall: out_data=%h out_valid=%b", bus.out_data, bus.out_valid);

    // Bubble behind a stalled stage 0
    drive(0, 1, 8'hA5, '0, '0, 0); cycle();
    drive(0, 0, '0, 3'b001, '0, 0); cycle();
    check("bubble_s1_valid", 128'(bus.out_valid[1]), 128'(0));
    check("bubble_s0_hold", 128'(bus.out_data[0 +: W]), 128'(8'hA5));
    drive(0, 0, '0, '0, '0, 0); cycle();
    check("bubble_advance", 128'(bus.out_data[W +: W]), 128'(8'hA5));
    $display("bubble: out_data=%h out_valid=%b", bus.out_data, bus.out_valid);

    // Flush and stall on stage 1 together
    drive(0, 1, 8'h5C, '0, '0, 0); cycle();
    drive(0, 1, 8'h77, '0, '0, 0); cycle();
    drive(0, 1, 8'h88, 3'b010, 3'b010, 0); cycle();
    drive(0, 1, 8'h88, 3'b010, '0, 0); cycle();
    check("flushstall_s1", 128'({bus.out_valid[1], bus.out_data[W +: W]}), 128'(0));
    check("flushstall_s0", 128'(bus.out_data[0 +: W]), 128'(8'h77));
    $display("flush_stall: out_data=%h out_valid=%b", bus.out_data, bus.out_valid);

    // Reset mid-stream with all stages full
    drive(0, 1, 8'h01, '0, '0, 0); cycle();
    drive(0, 1, 8'h02, '0, '0, 0); cycle();
    drive(0, 1, 8'h03, '0, '0, 0); cycle();
    drive(1, 1, 8'h04, 3'b011, 3'b100, 0); cycle();
    check("midreset", 128'({bus.out_valid, bus.out_data, bus.bubble_cnt}), 128'(0));
    $display("midreset: out_data=%h out_valid=%b", bus.out_data, bus.out_valid);

`ifdef CTRL_PIPE_PERF_EN
    // Saturation of the stage 0 counter
    drive(0, 0, '0, '0, '0, 0);
    force dut.gStage[0].uStage.bubbleCntReg = 32'hFFFF_FFFD;
    #1;
    release dut.gStage[0].uStage.bubbleCntReg;
    mC[0] = 32'hFFFF_FFFD;
    repeat (4) cycle();
    check("saturate", 128'(bus.bubble_cnt[31:0]), 128'(32'hFFFF_FFFF));
    drive(0, 0, '0, '0, '0, 1); cycle();
    check("perf_clr", 128'(bus.bubble_cnt[31:0]), 128'(0));
    $display("counters: bubble_cnt=%h", bus.bubble_cnt);
`endif

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [S-1:0] st;
      logic [S-1:0] fl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 4) == 0);
        fl[i] = ($urandom_range(0, 7) == 0);
      end
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, W'($urandom),
            st, fl, ($urandom_range(0, 15) == 0));
      cycle();
      $display("rand %0d: stall=%b flush=%b out_valid=%b out_data=%h",
               n, st, fl, bus.out_valid, bus.out_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
